// File: rtl/filtro_multi_if.sv
// Button filter bus: raw inputs and repeat enable in, filtered level and pulses out.
// Latency: none; this file only groups the signals.
// Backpressure: none; every output is a level or a single-cycle pulse.
interface filtro_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] F_IN;
  logic            F_REPEAT_EN;
  logic [N_CH-1:0] F_LEVEL;
  logic [N_CH-1:0] F_PRESS;
  logic [N_CH-1:0] F_RELEASE;

  // Stimulus side (board or testbench)
  modport master (
    output F_IN,
    output F_REPEAT_EN,
    input  F_LEVEL,
    input  F_PRESS,
    input  F_RELEASE
  );

  // Filter side
  modport slave (
    input  F_IN,
    input  F_REPEAT_EN,
    output F_LEVEL,
    output F_PRESS,
    output F_RELEASE
  );
endinterface

// File: rtl/filtro_multi.sv
// Multi-channel push-button filter: 2-flop sync, count debounce, press/release pulses, auto-repeat.
// Latency: level and press pulse appear DEBOUNCE_CYCLES+1 edges after the input is first sampled.
// Backpressure: none; pulses are one cycle wide and are not held for a consumer.
module filtro_multi #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 200
) (
  input  logic          F_CLOCK_50,
  input  logic          F_RESET_N,
  filtro_multi_if.slave bus
);

  localparam int CW      = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_e;

  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] press_vec;
  logic [N_CH-1:0] release_vec;

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    logic          s1_q, s2_q;
    logic          st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise, fall;
    state_e        state_q, state_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge F_CLOCK_50 or negedge F_RESET_N) begin
      if (!F_RESET_N) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= bus.F_IN[i];
        s2_q <= s1_q;
      end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      rise  = 1'b0;
      fall  = 1'b0;
      if (s2_q == st_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEB_LAST) begin
        st_d  = s2_q;
        cnt_d = '0;
        rise  = s2_q;
        fall  = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Press/repeat state machine; a falling level always beats a repeat terminal count
    always_comb begin
      state_d = state_q;
      rpt_d   = rpt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            press_d = 1'b1;
            state_d = ST_DELAY;
            rpt_d   = '0;
          end
        end
        ST_DELAY: begin
          if (fall) begin
            rel_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (!bus.F_REPEAT_EN) begin
            rpt_d = '0;
          end else if (rpt_q == DLY_LAST) begin
            press_d = 1'b1;
            state_d = ST_REPEAT;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (fall) begin
            rel_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (!bus.F_REPEAT_EN) begin
            // Disabling mid-hold falls back so that re-enabling waits the full delay again
            state_d = ST_DELAY;
            rpt_d   = '0;
          end else if (rpt_q == PER_LAST) begin
            press_d = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rpt_d   = '0;
        end
      endcase
    end

    // Channel state and registered outputs
    always_ff @(posedge F_CLOCK_50 or negedge F_RESET_N) begin
      if (!F_RESET_N) begin
        st_q    <= 1'b0;
        cnt_q   <= '0;
        state_q <= ST_IDLE;
        rpt_q   <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        state_q <= state_d;
        rpt_q   <= rpt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign level_vec[i]   = st_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = rel_q;
  end

  assign bus.F_LEVEL   = level_vec;
  assign bus.F_PRESS   = press_vec;
  assign bus.F_RELEASE = release_vec;

endmodule

// File: tb/tb_filtro_multi.sv
// Testbench for filtro_multi: expected pulse edges queued per scenario, popped as pulses appear.
// Latency: edges counted from the first edge that samples the scenario stimulus.
// Backpressure: none.
module tb_filtro_multi;
  localparam int N_CH = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  filtro_multi_if #(.N_CH(N_CH)) bus ();

  filtro_multi #(
    .N_CH(N_CH),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .F_CLOCK_50(clk),
    .F_RESET_N(rst_n),
    .bus(bus)
  );

  typedef struct {
    int ch;
    bit rel;
    int edge_n;
  } ev_t;

  typedef struct {
    int hi_len;
    int exp_press;
    int exp_rel;
  } vec_t;

  ev_t  exp_q[$];
  vec_t tbl[5];
  int   n_pass  = 0;
  int   n_total = 0;
  int   both_hi = 0;
  bit   lvl_seen;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic expect_ev(input int ch, input bit rel, input int e);
    ev_t x;
    x.ch = ch;
    x.rel = rel;
    x.edge_n = e;
    exp_q.push_back(x);
  endtask

  // Pulse code = edge*10 + ch*2 + rel, so one number identifies the whole event
  task automatic match(input int ch, input bit rel, input int e);
    ev_t x;
    if (exp_q.size() == 0) begin
      check("unexpected pulse code", 1'b0, e * 10 + ch * 2 + int'(rel), -1);
    end else begin
      x = exp_q.pop_front();
      check("pulse code", x.ch == ch && x.rel == rel && x.edge_n == e,
            e * 10 + ch * 2 + int'(rel), x.edge_n * 10 + x.ch * 2 + int'(x.rel));
      check("level at pulse", bus.F_LEVEL[ch] == !rel, int'(bus.F_LEVEL[ch]), int'(!rel));
    end
  endtask

  task automatic observe(input int e);
    for (int c = 0; c < N_CH; c++) begin
      if (bus.F_PRESS[c] && bus.F_RELEASE[c]) both_hi++;
      if (bus.F_PRESS[c]) match(c, 1'b0, e);
      if (bus.F_RELEASE[c]) match(c, 1'b1, e);
    end
    if (bus.F_LEVEL != '0) lvl_seen = 1'b1;
  endtask

  task automatic step(input logic [1:0] fin, input logic en, input int e);
    bus.F_IN = fin;
    bus.F_REPEAT_EN = en;
    @(posedge clk);
    #1;
    observe(e);
  endtask

  task automatic drain(input string name);
    check({name, " missing pulses"}, exp_q.size() == 0, exp_q.size(), 0);
    exp_q.delete();
    check({name, " press+release together"}, both_hi == 0, both_hi, 0);
    both_hi = 0;
    check({name, " final level"}, bus.F_LEVEL == '0, int'(bus.F_LEVEL), 0);
  endtask

  initial begin
    logic [1:0] f;
    logic       en;

    tbl[0] = '{40, 5, 45};
    tbl[1] = '{4, 5, 9};
    tbl[2] = '{3, -1, -1};
    tbl[3] = '{1, -1, -1};
    tbl[4] = '{10, 5, 15};

    bus.F_IN = '0;
    bus.F_REPEAT_EN = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {bus.F_LEVEL, bus.F_PRESS, bus.F_RELEASE} == '0,
          int'({bus.F_LEVEL, bus.F_PRESS, bus.F_RELEASE}), 0);
    rst_n = 1'b1;

    // Single pulses of various widths, repeat off
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].exp_press >= 0) expect_ev(0, 1'b0, tbl[i].exp_press);
      if (tbl[i].exp_rel >= 0) expect_ev(0, 1'b1, tbl[i].exp_rel);
      lvl_seen = 1'b0;
      for (int e = 0; e < tbl[i].hi_len + 14; e++)
        step((e < tbl[i].hi_len) ? 2'b01 : 2'b00, 1'b0, e);
      drain($sformatf("width %0d", tbl[i].hi_len));
      if (tbl[i].exp_press < 0)
        check($sformatf("width %0d level stayed low", tbl[i].hi_len), !lvl_seen, int'(lvl_seen), 0);
    end

    // Bounce: 3 high / 1 low never settles
    lvl_seen = 1'b0;
    for (int e = 0; e < 34; e++) step((e < 20 && (e % 4) < 3) ? 2'b01 : 2'b00, 1'b0, e);
    drain("bounce");
    check("bounce level stayed low", !lvl_seen, int'(lvl_seen), 0);

    // Auto-repeat, release collides with a repeat terminal count at edge 30
    expect_ev(0, 1'b0, 5);
    expect_ev(0, 1'b0, 15);
    expect_ev(0, 1'b0, 18);
    expect_ev(0, 1'b0, 21);
    expect_ev(0, 1'b0, 24);
    expect_ev(0, 1'b0, 27);
    expect_ev(0, 1'b1, 30);
    for (int e = 0; e < 40; e++) step((e < 25) ? 2'b01 : 2'b00, 1'b1, e);
    drain("repeat collision");

    // Channel independence: ch1 lags ch0 by 2, ch0 glitches low while held
    expect_ev(0, 1'b0, 5);
    expect_ev(1, 1'b0, 7);
    expect_ev(0, 1'b1, 40);
    expect_ev(1, 1'b1, 50);
    for (int e = 0; e < 60; e++) begin
      f[0] = (e < 15) ? 1'b1 : ((e < 35) ? ((e % 4) != 0) : 1'b0);
      f[1] = (e >= 2 && e < 45);
      step(f, 1'b0, e);
    end
    drain("independence");

    // Reset during REPEAT with the button still held
    expect_ev(0, 1'b0, 5);
    expect_ev(0, 1'b0, 15);
    expect_ev(0, 1'b0, 18);
    for (int e = 0; e < 20; e++) step(2'b01, 1'b1, e);
    check("pre-reset pending", exp_q.size() == 0, exp_q.size(), 0);
    exp_q.delete();
    check("pre-reset level high", bus.F_LEVEL[0] == 1'b1, int'(bus.F_LEVEL[0]), 1);
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {bus.F_LEVEL, bus.F_PRESS, bus.F_RELEASE} == '0,
          int'({bus.F_LEVEL, bus.F_PRESS, bus.F_RELEASE}), 0);
    repeat (3) @(posedge clk);
    #1;
    check("held reset outputs", {bus.F_LEVEL, bus.F_PRESS, bus.F_RELEASE} == '0,
          int'({bus.F_LEVEL, bus.F_PRESS, bus.F_RELEASE}), 0);
    rst_n = 1'b1;
    expect_ev(0, 1'b0, 5);
    expect_ev(0, 1'b0, 15);
    expect_ev(0, 1'b0, 18);
    expect_ev(0, 1'b1, 21);
    for (int e = 0; e < 36; e++) step((e < 16) ? 2'b01 : 2'b00, 1'b1, e);
    drain("post-reset");

    // Repeat disabled mid-hold, then re-enabled: full delay restarts
    expect_ev(0, 1'b0, 5);
    expect_ev(0, 1'b0, 15);
    expect_ev(0, 1'b0, 40);
    expect_ev(0, 1'b0, 43);
    expect_ev(0, 1'b0, 46);
    expect_ev(0, 1'b1, 47);
    for (int e = 0; e < 56; e++) begin
      en = !(e >= 17 && e < 31);
      step((e < 42) ? 2'b01 : 2'b00, en, e);
    end
    drain("repeat toggle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/filtro_multi.md
Name: filtro_multi

Overview:
- Parametrised multi-channel successor to the single-channel push-button pulse filter.
- Per channel: synchronises a raw button input, debounces it with a cycle-count filter, outputs the stable level, and emits one-cycle press and release pulses.
- Optional auto-repeat: while a button is held, extra press pulses are generated at a programmable delay and then at a fixed period.
- Sits between the board push-buttons and the game control FSMs.

Parameters:
- N_CH, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive cycles the synchronised input must differ from the stable level before the level flips (>=1).
- REPEAT_DELAY, 1000, cycles from the press pulse to the first repeat pulse (>=1).
- REPEAT_PERIOD, 200, cycles between subsequent repeat pulses (>=1).

Ports:
- F_CLOCK_50  in  1  system clock; all logic on its rising edge.
- F_RESET_N  in  1  asynchronous, active-low reset.
- F_IN  in  N_CH  raw button inputs, asynchronous to the clock.
- F_REPEAT_EN  in  1  global auto-repeat enable (synchronous level).
- F_LEVEL  out  N_CH  debounced stable level per channel.
- F_PRESS  out  N_CH  one-cycle pulse on debounced rise, and on each auto-repeat.
- F_RELEASE  out  N_CH  one-cycle pulse on debounced fall.

Behaviour:
- Reset (F_RESET_N=0, asynchronous): all outputs 0; sync flops, stable levels, counters 0; all channel FSMs in IDLE.
- Synchroniser, per channel: s1<=F_IN[i], s2<=s1. All outputs are registered.
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If s2==st, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1, then st<=s2 and cnt<=0.
  - Else cnt<=cnt+1.
  - F_LEVEL[i]=st.
- Latency: take the first edge sampling F_IN high as edge 0. With the input held, F_LEVEL rises and F_PRESS pulses after edge DEBOUNCE_CYCLES+1. Release is symmetric, with F_RELEASE pulsing on the edge F_LEVEL falls.
- Glitch rejection: any input pulse or gap shorter than DEBOUNCE_CYCLES cycles at s2 resets cnt and causes no output change.
- Per-channel FSM (repeat counter rpt, width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)):
  - IDLE: on the edge st rises, F_PRESS=1, go to DELAY, rpt<=0.
  - DELAY:
    - If st falls, F_RELEASE=1, go to IDLE.
    - Else if F_REPEAT_EN=0, rpt held at 0.
    - Else if rpt==REPEAT_DELAY-1, F_PRESS=1, go to REPEAT, rpt<=0.
    - Else rpt++.
  - REPEAT:
    - If st falls, F_RELEASE=1, go to IDLE.
    - Else if F_REPEAT_EN=0, go to DELAY, rpt<=0.
    - Else if rpt==REPEAT_PERIOD-1, F_PRESS=1, rpt<=0.
    - Else rpt++.
- Simultaneous events: st falling on the same edge as a repeat terminal count gives release priority. No F_PRESS is emitted that cycle; only F_RELEASE.
- F_PRESS and F_RELEASE are never high together on a channel. Pulses are exactly one cycle wide.
- Channels are fully independent; there is no cross-channel arbitration.
- Reset mid-operation clears everything immediately.
  - If F_IN is still high after reset release, it is treated as a new press: F_PRESS after edge DEBOUNCE_CYCLES+1 counted from the first post-reset edge.
- Disabling repeat mid-hold stops further repeats. Re-enabling restarts the full REPEAT_DELAY from that point.

Test Plan:
(Bench params: N_CH=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3. Edge numbers are relative to the first sampling edge of the stimulus.)
- Clean press/release, repeat off: F_IN[0]=1 from edge 0 to edge 39, then 0 -> F_LEVEL[0] rises and F_PRESS[0] pulses once after edge 5; F_LEVEL[0] falls and F_RELEASE[0] pulses after edge 45; no other pulses.
- Bounce: F_IN[0] alternates 3 cycles high / 1 cycle low for 20 cycles, then stays low -> F_LEVEL[0], F_PRESS[0] and F_RELEASE[0] stay 0 throughout.
- Auto-repeat with release collision: F_REPEAT_EN=1, F_IN[0] high from edge 0, low from edge 25 -> F_PRESS[0] after edges 5, 15, 18, 21, 24, 27; at edge 30 F_RELEASE[0]=1 and F_PRESS[0]=0 (release wins).
- Channel independence: F_IN[1] rises 2 cycles after F_IN[0] while F_IN[0] later bounces -> F_PRESS[1] after edge 7; ch1 outputs unaffected by the ch0 activity.
- Reset mid-REPEAT: F_RESET_N=0 for 3 cycles with F_IN[0] held high -> all outputs 0 immediately; after release F_PRESS[0] after post-reset edge 5, first repeat at edge 15.
- Repeat toggle: drop F_REPEAT_EN at edge 16 during REPEAT, raise it at edge 30 with the button held -> no F_PRESS between edges 16 and 39; next F_PRESS after edge 40.
